// File: rtl/sramlike_pkg.sv
// Shared definitions for the data-side SRAM-to-SRAM-like bridge.
// Contents:
//   - state_t : bridge FSM state encoding (IDLE/REQ/WAIT/HOLD)
//   - SZ_*    : data_size codes driven on the SRAM-like bus
package sramlike_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

endpackage

// File: rtl/data_sramlike_bridge_wen_decode.sv
// Byte-enable decoder for the SRAM-like bridge (purely combinational).
// Ports:
//   wen    : byte write enables (all zero means read)
//   size   : transfer size code; reads and non-contiguous or odd-count
//            masks report full width
//   offset : index of the lowest set wen bit (0 for reads)
module wen_decode
  import sramlike_pkg::*;
#(
  parameter  int WEN_W = 4,
  localparam int OFF_W = $clog2(WEN_W)
) (
  input  logic [WEN_W-1:0] wen,
  output logic [1:0]       size,
  output logic [OFF_W-1:0] offset
);

  localparam logic [1:0]       SZ_FULL = 2'(OFF_W);
  localparam logic [WEN_W-1:0] ONE     = WEN_W'(1);

  logic [WEN_W-1:0] shifted;
  logic             found;
  logic             contig;
  int               cnt;

  always_comb begin
    offset = '0;
    found  = 1'b0;
    cnt    = 0;
    for (int i = 0; i < WEN_W; i++) begin
      if (wen[i]) begin
        cnt = cnt + 1;
        if (!found) begin
          offset = i[OFF_W-1:0];
          found  = 1'b1;
        end
      end
    end
    // After shifting the lowest set bit to position 0, a contiguous run
    // looks like 0..01..1, which has no bit in common with itself + 1.
    shifted = wen >> offset;
    contig  = ((shifted & (shifted + ONE)) == '0);
    size    = SZ_FULL;
    if (found && contig) begin
      case (cnt)
        1:       size = SZ_BYTE;
        2:       size = SZ_HALF;
        4:       size = SZ_WORD;
        8:       size = SZ_DWORD;
        default: size = SZ_FULL;
      endcase
    end
  end

endmodule

// File: rtl/data_sramlike_bridge.sv
// Data-side bridge: turns a single-cycle SRAM-style MEM-stage access into
// one SRAM-like transaction and stalls the pipeline until data returns.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   data_sram_en/wen/addr/wdata : SRAM-style access from the MEM stage
//   data_sram_rdata        : read data, held until the pipeline advances
//   d_stall                : stall request to the pipeline
//   ext_stall              : other stall sources (any bit freezes pipeline)
//   flush                  : exception/eret flush of the MEM stage
//   data_req/wr/size/addr/wdata : SRAM-like request (from latched attrs)
//   data_rdata, data_addr_ok, data_data_ok : SRAM-like response
module data_sramlike_bridge
  import sramlike_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int EXT_STALL_N = 1,
  parameter  int ALIGN_ADDR  = 1,
  localparam int WEN_W       = DATA_W / 8,
  localparam int OFF_W       = $clog2(WEN_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_sram_en,
  input  logic [WEN_W-1:0]       data_sram_wen,
  input  logic [ADDR_W-1:0]      data_sram_addr,
  input  logic [DATA_W-1:0]      data_sram_wdata,
  output logic [DATA_W-1:0]      data_sram_rdata,
  output logic                   d_stall,
  input  logic [EXT_STALL_N-1:0] ext_stall,
  input  logic                   flush,
  output logic                   data_req,
  output logic                   data_wr,
  output logic [1:0]             data_size,
  output logic [ADDR_W-1:0]      data_addr,
  output logic [DATA_W-1:0]      data_wdata,
  input  logic [DATA_W-1:0]      data_rdata,
  input  logic                   data_addr_ok,
  input  logic                   data_data_ok
);

  state_t state_q, state_d;
  logic   cancel_q, cancel_d;
  logic   latch_en, capture, adv;

  logic [1:0]        dec_size;
  logic [OFF_W-1:0]  dec_off;
  logic [ADDR_W-1:0] addr_next;

  logic              req_wr_p0;
  logic [1:0]        req_size_p0;
  logic [ADDR_W-1:0] req_addr_p0;
  logic [DATA_W-1:0] req_wdata_p0;

  wen_decode #(.WEN_W(WEN_W)) u_wen_decode (
    .wen    (data_sram_wen),
    .size   (dec_size),
    .offset (dec_off)
  );

  always_comb begin
    addr_next = data_sram_addr;
    if (ALIGN_ADDR != 0 && data_sram_wen != '0)
      addr_next[OFF_W-1:0] = dec_off;
  end

  assign d_stall = data_sram_en & (state_q != S_HOLD);
  assign adv     = ~d_stall & ~|ext_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    latch_en = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_sram_en && !flush) begin
          latch_en = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          // Once the address is accepted the bus owes us a data_ok, so we
          // must wait it out and discard it rather than drop back to IDLE.
          if (data_addr_ok && !data_data_ok) begin
            state_d  = S_WAIT;
            cancel_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = S_HOLD;
            capture = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (data_data_ok) begin
          if (cancel_q || flush) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_HOLD;
            capture = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (adv || flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request stage: attributes latched at issue, stable while data_req is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr_p0    <= 1'b0;
      req_size_p0  <= 2'd0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
    end else if (latch_en) begin
      req_wr_p0    <= (data_sram_wen != '0);
      req_size_p0  <= dec_size;
      req_addr_p0  <= addr_next;
      req_wdata_p0 <= data_sram_wdata;
    end
  end

  // Response stage: read data held until the pipeline advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_sram_rdata <= '0;
    else if (capture) data_sram_rdata <= data_rdata;
  end

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = req_wr_p0;
  assign data_size  = req_size_p0;
  assign data_addr  = req_addr_p0;
  assign data_wdata = req_wdata_p0;

endmodule

// File: tb/tb_data_sramlike_bridge.sv
module tb_data_sramlike_bridge;
  import sramlike_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] addr;
  logic [0:0]  ext_stall;
  logic        flush, addr_ok, data_ok;

  logic [3:0]  wen;
  logic [31:0] wdata, rdata_in, rdata;
  logic        d_stall, req, wr;
  logic [1:0]  size;
  logic [31:0] daddr, dwdata;

  logic [7:0]  wen64;
  logic [63:0] wdata64, rdata_in64, rdata64;
  logic        d_stall64, req64, wr64;
  logic [1:0]  size64;
  logic [31:0] daddr64;
  logic [63:0] dwdata64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_sramlike_bridge #(.ADDR_W(32), .DATA_W(32), .EXT_STALL_N(1), .ALIGN_ADDR(1)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata), .d_stall(d_stall),
    .ext_stall(ext_stall), .flush(flush),
    .data_req(req), .data_wr(wr), .data_size(size), .data_addr(daddr),
    .data_wdata(dwdata), .data_rdata(rdata_in),
    .data_addr_ok(addr_ok), .data_data_ok(data_ok)
  );

  data_sramlike_bridge #(.ADDR_W(32), .DATA_W(64), .EXT_STALL_N(1), .ALIGN_ADDR(1)) dut64 (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen64), .data_sram_addr(addr),
    .data_sram_wdata(wdata64), .data_sram_rdata(rdata64), .d_stall(d_stall64),
    .ext_stall(ext_stall), .flush(flush),
    .data_req(req64), .data_wr(wr64), .data_size(size64), .data_addr(daddr64),
    .data_wdata(dwdata64), .data_rdata(rdata_in64),
    .data_addr_ok(addr_ok), .data_data_ok(data_ok)
  );

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; addr = '0; ext_stall = '0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0;
    wen = '0; wdata = '0; rdata_in = '0;
    wen64 = '0; wdata64 = '0; rdata_in64 = '0;
    #2;
    chk("rst_req", req === 1'b0, 64'(req), 64'(1'b0));
    chk("rst_rdata", rdata === 32'h0, 64'(rdata), 64'(32'h0));
    chk("rst_wr", wr === 1'b0, 64'(wr), 64'(1'b0));
    chk("rst_addr", daddr === 32'h0, 64'(daddr), 64'(32'h0));
    chk("rst_dstall", d_stall === 1'b0, 64'(d_stall), 64'(1'b0));
    chk("rst_state", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: read at 0x1000, addr_ok late, data_ok later
    en = 1'b1; wen = 4'b0000; wen64 = 8'h00; addr = 32'h1000;
    #1;
    chk("t1_idle_dstall", d_stall === 1'b1, 64'(d_stall), 64'(1'b1));
    chk("t1_idle_req", req === 1'b0, 64'(req), 64'(1'b0));
    tick();
    chk("t1_req", req === 1'b1, 64'(req), 64'(1'b1));
    chk("t1_addr", daddr === 32'h1000, 64'(daddr), 64'(32'h1000));
    chk("t1_wr", wr === 1'b0, 64'(wr), 64'(1'b0));
    chk("t1_size", size === SZ_WORD, 64'(size), 64'(SZ_WORD));
    chk("t1_size64", size64 === SZ_DWORD, 64'(size64), 64'(SZ_DWORD));
    chk("t1_dstall", d_stall === 1'b1, 64'(d_stall), 64'(1'b1));
    tick();
    chk("t1_req_hold", req === 1'b1, 64'(req), 64'(1'b1));
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("t1_wait_req", req === 1'b0, 64'(req), 64'(1'b0));
    chk("t1_wait_dstall", d_stall === 1'b1, 64'(d_stall), 64'(1'b1));
    tick();
    chk("t1_wait_state", dut.state_q === S_WAIT, 64'(dut.state_q), 64'(S_WAIT));
    data_ok = 1'b1; rdata_in = 32'hDEADBEEF; rdata_in64 = 64'h0123_4567_89AB_CDEF;
    tick();
    data_ok = 1'b0;
    chk("t1_rdata", rdata === 32'hDEADBEEF, 64'(rdata), 64'(32'hDEADBEEF));
    chk("t1_rdata64", rdata64 === 64'h0123_4567_89AB_CDEF, rdata64, 64'h0123_4567_89AB_CDEF);
    chk("t1_hold_dstall", d_stall === 1'b0, 64'(d_stall), 64'(1'b0));
    en = 1'b0;
    tick();
    chk("t1_idle_state", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    chk("t1_rdata_kept", rdata === 32'hDEADBEEF, 64'(rdata), 64'(32'hDEADBEEF));

    // 2: byte store, aligned address, attributes stable while req high
    en = 1'b1; wen = 4'b0100; wen64 = 8'b0011_0000; addr = 32'h2000; wdata = 32'hAABBCCDD;
    tick();
    chk("t2_wr", wr === 1'b1, 64'(wr), 64'(1'b1));
    chk("t2_size", size === SZ_BYTE, 64'(size), 64'(SZ_BYTE));
    chk("t2_addr", daddr === 32'h2002, 64'(daddr), 64'(32'h2002));
    chk("t2_wdata", dwdata === 32'hAABBCCDD, 64'(dwdata), 64'(32'hAABBCCDD));
    chk("t2_size64", size64 === SZ_HALF, 64'(size64), 64'(SZ_HALF));
    chk("t2_addr64", daddr64 === 32'h2004, 64'(daddr64), 64'(32'h2004));
    addr = 32'h3000; wdata = 32'h0; wen = 4'b0000; wen64 = 8'h00;
    tick();
    chk("t2_req_still", req === 1'b1, 64'(req), 64'(1'b1));
    chk("t2_addr_stable", daddr === 32'h2002, 64'(daddr), 64'(32'h2002));
    chk("t2_wr_stable", wr === 1'b1, 64'(wr), 64'(1'b1));
    chk("t2_wdata_stable", dwdata === 32'hAABBCCDD, 64'(dwdata), 64'(32'hAABBCCDD));
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1; rdata_in = 32'h0000_5555;
    tick();
    data_ok = 1'b0;
    chk("t2_rdata", rdata === 32'h0000_5555, 64'(rdata), 64'(32'h0000_5555));
    en = 1'b0;
    tick();

    // 3+4: addr_ok and data_ok together, then held by ext_stall
    en = 1'b1; wen = 4'b0000; addr = 32'h1004;
    tick();
    addr_ok = 1'b1; data_ok = 1'b1; rdata_in = 32'hCAFEF00D; ext_stall = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("t3_state_hold", dut.state_q === S_HOLD, 64'(dut.state_q), 64'(S_HOLD));
    chk("t3_rdata", rdata === 32'hCAFEF00D, 64'(rdata), 64'(32'hCAFEF00D));
    chk("t3_req", req === 1'b0, 64'(req), 64'(1'b0));
    chk("t3_dstall", d_stall === 1'b0, 64'(d_stall), 64'(1'b0));
    rdata_in = 32'h1111_1111;
    tick();
    data_ok = 1'b0;
    chk("t4_state_hold2", dut.state_q === S_HOLD, 64'(dut.state_q), 64'(S_HOLD));
    chk("t4_rdata_hold2", rdata === 32'hCAFEF00D, 64'(rdata), 64'(32'hCAFEF00D));
    tick();
    chk("t4_state_hold3", dut.state_q === S_HOLD, 64'(dut.state_q), 64'(S_HOLD));
    chk("t4_rdata_hold3", rdata === 32'hCAFEF00D, 64'(rdata), 64'(32'hCAFEF00D));
    ext_stall = 1'b0;
    tick();
    chk("t4_state_idle", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    chk("t4_rdata_after", rdata === 32'hCAFEF00D, 64'(rdata), 64'(32'hCAFEF00D));
    chk("t4_idle_dstall", d_stall === 1'b1, 64'(d_stall), 64'(1'b1));
    en = 1'b0;
    tick();

    // 5a: flush in REQ before addr_ok withdraws the request
    en = 1'b1; addr = 32'h1008;
    tick();
    chk("t5a_req", req === 1'b1, 64'(req), 64'(1'b1));
    flush = 1'b1;
    tick();
    chk("t5a_req_drop", req === 1'b0, 64'(req), 64'(1'b0));
    chk("t5a_state", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    flush = 1'b0; en = 1'b0;
    tick();
    chk("t5a_no_req", req === 1'b0, 64'(req), 64'(1'b0));

    // 5b: flush in WAIT discards the following data_ok
    en = 1'b1; addr = 32'h100C;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; flush = 1'b1; en = 1'b0;
    tick();
    flush = 1'b0;
    chk("t5b_state_wait", dut.state_q === S_WAIT, 64'(dut.state_q), 64'(S_WAIT));
    chk("t5b_cancel", dut.cancel_q === 1'b1, 64'(dut.cancel_q), 64'(1'b1));
    data_ok = 1'b1; rdata_in = 32'h1234_5678;
    tick();
    data_ok = 1'b0;
    chk("t5b_rdata_kept", rdata === 32'hCAFEF00D, 64'(rdata), 64'(32'hCAFEF00D));
    chk("t5b_state_idle", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    chk("t5b_cancel_clr", dut.cancel_q === 1'b0, 64'(dut.cancel_q), 64'(1'b0));

    // 6: non-contiguous store, then async reset during WAIT
    en = 1'b1; wen = 4'b1001; addr = 32'h1010; wdata = 32'h0BAD_F00D;
    tick();
    chk("t6_size_noncontig", size === SZ_WORD, 64'(size), 64'(SZ_WORD));
    chk("t6_addr", daddr === 32'h1010, 64'(daddr), 64'(32'h1010));
    chk("t6_wr", wr === 1'b1, 64'(wr), 64'(1'b1));
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("t6_state_wait", dut.state_q === S_WAIT, 64'(dut.state_q), 64'(S_WAIT));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_req", req === 1'b0, 64'(req), 64'(1'b0));
    chk("t6_rst_rdata", rdata === 32'h0, 64'(rdata), 64'(32'h0));
    chk("t6_rst_rdata64", rdata64 === 64'h0, rdata64, 64'h0);
    chk("t6_rst_state", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));
    chk("t6_rst_addr", daddr === 32'h0, 64'(daddr), 64'(32'h0));
    chk("t6_rst_wr", wr === 1'b0, 64'(wr), 64'(1'b0));
    en = 1'b0; wen = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_post_state", dut.state_q === S_IDLE, 64'(dut.state_q), 64'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sramlike_bridge.md
Name: data_sramlike_bridge

Overview:
- Parametrised successor to the data-side SRAM-to-SRAM-like converter. Sits between the CPU MEM stage and the AXI/cache bridge.
- Converts a single-cycle SRAM-style access into one SRAM-like transaction and stalls the pipeline until data returns.
- New over the previous generation:
  - configurable data width and any number of external stall sources;
  - request attributes are latched, so they stay stable while `data_req` is high;
  - byte-aligned address generation;
  - exception flush with a cancel path for in-flight requests.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; 32 or 64 only. WEN_W = DATA_W/8.
- EXT_STALL_N, 1, number of external pipeline-stall sources; replaces the single `div_stall`.
- ALIGN_ADDR, 1:
  - 1: on writes, the low log2(WEN_W) address bits are replaced by the index of the lowest set `wen` bit.
  - 0: address passes through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_sram_en  in  1  access valid this cycle
- data_sram_wen  in  WEN_W  byte write enables; all zero means read
- data_sram_addr  in  ADDR_W  byte address
- data_sram_wdata  in  DATA_W  write data
- data_sram_rdata  out  DATA_W  held read data
- d_stall  out  1  stall request to the pipeline
- ext_stall  in  EXT_STALL_N  other stall sources; any bit set freezes the pipeline
- flush  in  1  exception/eret flush of the MEM stage
- data_req  out  1  SRAM-like request
- data_wr  out  1  write flag
- data_size  out  2  0=byte, 1=half, 2=word, 3=dword
- data_addr  out  ADDR_W  request address
- data_wdata  out  DATA_W  request write data
- data_rdata  in  DATA_W  read data from the bridge
- data_addr_ok  in  1  address handshake
- data_data_ok  in  1  data handshake

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cancel=0, data_sram_rdata=0, all latched attributes=0.
  - Hence data_req=0 and data_wr/size/addr/wdata=0.
- FSM states: IDLE, REQ, WAIT, HOLD. Define adv = ~d_stall & ~|ext_stall.
- IDLE:
  - If en & ~flush: latch wr=(wen!=0), size, addr, wdata; go to REQ.
  - Issue latency is 1 cycle after en.
- REQ:
  - Drive data_req=1 from the latched attributes.
  - addr_ok & data_ok → HOLD, capture rdata.
  - addr_ok & ~data_ok → WAIT.
  - flush & ~addr_ok → IDLE; the request is withdrawn.
  - flush & addr_ok → WAIT with cancel=1.
- WAIT:
  - data_req=0. A flush in this state sets cancel.
  - data_ok & ~cancel → HOLD, capture rdata.
  - data_ok & cancel → IDLE, clear cancel; rdata is not updated.
- HOLD:
  - adv or flush → IDLE.
  - Otherwise stay. rdata remains stable for as long as ext_stall holds the pipeline.
- data_wr, size, addr and wdata come only from the latch and are constant across a request.
- d_stall = en & (state != HOLD). This is combinational, is 0 when en=0, and also covers the cycle that finishes a cancelled WAIT.
- Size encoding:
  - wen popcount 1→0, 2→1, 4→2, 8→3.
  - Reads use log2(WEN_W).
  - Any non-contiguous wen is treated as full width.
- data_ok outside REQ/WAIT is ignored.
- At most one outstanding transaction exists at any time.

Decomposition:
- pkg `sramlike_pkg`: state encoding constants (IDLE/REQ/WAIT/HOLD) and the size codes.
- Sub-module `wen_decode`: combinational; wen → size and low address offset, parametrised by WEN_W.
- The FSM and latches live in the top module.

Test Plan:
1. Read at 0x1000, addr_ok in cycle 2 and data_ok in cycle 4 with rdata=0xDEADBEEF:
   - req is high in cycle 1 only until addr_ok;
   - d_stall is high until HOLD;
   - rdata reads 0xDEADBEEF and d_stall falls in cycle 5.
2. Store byte, wen=4'b0100, addr 0x2000, ALIGN_ADDR=1:
   - data_wr=1, size=0, data_addr=0x2002;
   - the sram-side addr is changed while req is high, and data_addr stays 0x2002.
3. addr_ok and data_ok in the same cycle → REQ goes directly to HOLD with no WAIT cycle, and data is captured.
4. ext_stall=1 for 3 cycles after data_ok → rdata is held constant and state stays HOLD; IDLE follows on the first cycle where ext_stall=0.
5. Flush in REQ before addr_ok → req drops the next cycle and the bus sees no transaction. Flush in WAIT → the following data_ok (0x12345678) is discarded, rdata is unchanged and state returns to IDLE.
6. rst pulsed low during WAIT → immediately req=0, rdata=0, state=IDLE. DATA_W=64 read → size=3.
